mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between two requesters: the instruction fetch (IF) stage and the data access (MEM) stage of the RV64 5-stage pipeline.
- Sequences each transaction with a req/ack handshake and returns read data to the granted requester.
- Raises a pipeline stall while any request is outstanding.
- Gives data accesses priority, with a starvation limit so fetch always makes progress.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before IF is forced to win (range 1-15)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  synchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_ready  out  1  1-cycle pulse: fetch done, if_inst valid
if_inst  out  32  fetched word; mem_rdata[63:32] if latched addr[2]=1, else mem_rdata[31:0]
d_req  in  1  data request; held with d_* fields until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_wdata  in  64  store data
d_wmask  in  8  store byte mask
d_ready  out  1  1-cycle pulse: data access done, d_rdata valid (loads)
d_rdata  out  64  load data, raw 64-bit word
stall  out  1  combinational: (if_req|d_req) & ~(if_ready|d_ready)
mem_req  out  1  memory request, registered
mem_we  out  1  registered write enable
mem_addr  out  32  registered address; {if_addr[31:3],3'b000} for fetch
mem_wdata  out  64  registered write data
mem_wmask  out  8  registered mask; 8'h00 for fetch
mem_ack  in  1  memory completion; valid only while mem_req=1
mem_rdata  in  64  read data, valid with mem_ack
perf_if_cnt, perf_d_cnt, perf_wait_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (nrst=0 at edge): state IDLE; mem_req, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, mem_wmask, if_inst, d_rdata = 0; starve counter = 0.
- Reset mid-transaction abandons it: mem_req drops on the reset edge and no ready pulse is issued. The memory tolerates a dropped request.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE, at a clock edge:
  - If any request is present, select the winner, latch its fields into mem_* registers, set mem_req=1 and go to BUSY_IF or BUSY_D.
  - If no request is present, stay in IDLE.
- Arbitration, in IDLE only:
  - d_req only -> data wins. if_req only -> fetch wins.
  - Both present -> data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4-bit):
  - +1 on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Cleared to 0 on any fetch grant.
  - Unchanged on a data grant with if_req=0.
- BUSY_x:
  - mem_* fields are held stable.
  - On mem_ack=1: capture mem_rdata into if_inst (word select by latched addr[2]) or d_rdata; clear mem_req; pulse x_ready for the next cycle; return to IDLE.
  - mem_ack may arrive in the first mem_req cycle.
- Minimum latency: request present at edge E0 -> mem_req high cycle 1 -> ack in cycle 1 -> x_ready high cycle 2. Total: 2 cycles from request to ready.
- During the ready cycle the FSM is in IDLE. A requester keeping req high at the end of that cycle is treated as a new request, so requesters update or drop req in the ready cycle.
- if_ready and d_ready are never high together.
- mem_ack while mem_req=0 is ignored.
- The non-granted request waits; its inputs are not sampled until its own grant.
- Fetch never writes: mem_we=0, mem_wmask=0.
- d_rdata and if_inst hold their values until overwritten by the next completion of the same type.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - perf_if_cnt increments on each if_ready.
  - perf_d_cnt increments on each d_ready.
  - perf_wait_cnt increments each cycle with stall=1.
  - All three wrap at 2^32 and reset to 0.
- Undefined: the three outputs are tied to 32'h0 and no counter logic is generated.

Test Plan:
- Reset then single fetch, if_addr=0x0000_0104, mem_ack 1 cycle after mem_req with mem_rdata=0xAABBCCDD_11223344 -> mem_addr=0x100, mem_wmask=0, if_ready pulses once, if_inst=0xAABBCCDD, stall deasserted in the ready cycle.
- Store d_we=1, d_addr=0x200, d_wdata=0x0123456789ABCDEF, d_wmask=0x0F, ack after 3 wait cycles -> mem_* fields stable for all 4 req cycles, d_ready pulses once, mem_req low the cycle after ack.
- if_req and d_req held continuously, STARVE_LIMIT=4, immediate acks -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Same-cycle ack: mem_ack asserted in the first mem_req cycle for a load -> d_ready exactly 2 cycles after the request edge, d_rdata = mem_rdata.
- nrst=0 while in BUSY_D before ack -> mem_req=0 next cycle, no d_ready, all outputs 0. After release, d_req is re-arbitrated and completes normally.
- ARB_PERF_CNT_EN defined, 3 fetches + 2 loads with 1-cycle-delayed acks -> perf_if_cnt=3, perf_d_cnt=2, perf_wait_cnt equals the total stall cycles. Undefined: all three counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified memory-port signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_inst;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wmask;
  logic        d_ready;
  logic [63:0] d_rdata;

  logic        stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic [31:0] perf_if_cnt;
  logic [31:0] perf_d_cnt;
  logic [31:0] perf_wait_cnt;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
    output if_ready, if_inst, d_ready, d_rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output perf_if_cnt, perf_d_cnt, perf_wait_cnt
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
    input  if_ready, if_inst, d_ready, d_rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  perf_if_cnt, perf_d_cnt, perf_wait_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and data access, data first
// with a starvation limit for fetch. Define ARB_PERF_CNT_EN to build the perf counters.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               nrst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic        if_hi_q, if_hi_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        d_ready_q, d_ready_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic idle, starved, grant_d, grant_if, stall;

  // Fetch address bits [1:0] never reach the port; word select comes from bit 2 only.
  logic unused_if_addr;
  assign unused_if_addr = ^bus.if_addr[1:0];

  assign idle     = (state_q == StIdle);
  assign starved  = (starve_cnt_q == StarveMax);
  assign grant_d  = idle & bus.d_req & ~(bus.if_req & starved);
  assign grant_if = idle & bus.if_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      if_hi_q      <= 1'b0;
      if_ready_q   <= 1'b0;
      if_inst_q    <= '0;
      d_ready_q    <= 1'b0;
      d_rdata_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      if_hi_q      <= if_hi_d;
      if_ready_q   <= if_ready_d;
      if_inst_q    <= if_inst_d;
      d_ready_q    <= d_ready_d;
      d_rdata_q    <= d_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StBusyD;
        end else if (grant_if) begin
          state_d = StBusyIf;
        end
      end
      StBusyIf, StBusyD: begin
        if (bus.mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    if_hi_d      = if_hi_q;
    if_inst_d    = if_inst_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_wmask_d = bus.d_wmask;
          // Only data grants that pass over a waiting fetch count toward starvation.
          if (bus.if_req && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (grant_if) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {bus.if_addr[31:3], 3'b000};
          mem_wdata_d  = '0;
          mem_wmask_d  = 8'h00;
          if_hi_d      = bus.if_addr[2];
          starve_cnt_d = '0;
        end
      end
      StBusyIf: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_inst_d  = if_hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
        end
      end
      StBusyD: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          d_rdata_d = bus.mem_rdata;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  assign stall = (bus.if_req | bus.d_req) & ~(if_ready_q | d_ready_q);

  assign bus.stall     = stall;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt_q, perf_if_cnt_d;
  logic [31:0] perf_d_cnt_q, perf_d_cnt_d;
  logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;

  always_comb begin
    perf_if_cnt_d   = perf_if_cnt_q + {31'd0, if_ready_q};
    perf_d_cnt_d    = perf_d_cnt_q + {31'd0, d_ready_q};
    perf_wait_cnt_d = perf_wait_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      perf_if_cnt_q   <= '0;
      perf_d_cnt_q    <= '0;
      perf_wait_cnt_q <= '0;
    end else begin
      perf_if_cnt_q   <= perf_if_cnt_d;
      perf_d_cnt_q    <= perf_d_cnt_d;
      perf_wait_cnt_q <= perf_wait_cnt_d;
    end
  end

  assign bus.perf_if_cnt   = perf_if_cnt_q;
  assign bus.perf_d_cnt    = perf_d_cnt_q;
  assign bus.perf_wait_cnt = perf_wait_cnt_q;
`else
  assign bus.perf_if_cnt   = 32'h0;
  assign bus.perf_d_cnt    = 32'h0;
  assign bus.perf_wait_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/store/load transactions, starvation order,
// same-cycle ack, mid-transaction reset and perf counters (ARB_PERF_CNT_EN aware).
module tb_mem_port_arbiter;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_wmask   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive_idle();
    tick();
    tick();
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 64'h0);
    check_eq("rst_mem_wmask", bus.mem_wmask, 8'h0);
    check_eq("rst_if_ready", bus.if_ready, 1'b0);
    check_eq("rst_d_ready", bus.d_ready, 1'b0);
    check_eq("rst_if_inst", bus.if_inst, 32'h0);
    check_eq("rst_d_rdata", bus.d_rdata, 64'h0);
    check_eq("rst_stall", bus.stall, 1'b0);
    check_eq("rst_perf_if", bus.perf_if_cnt, 32'h0);
    check_eq("rst_perf_wait", bus.perf_wait_cnt, 32'h0);
    nrst = 1'b1;
  endtask

  // One complete transaction; ack is given after `delay` extra mem_req cycles.
  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input logic [63:0] rdata, input int delay,
                         input logic [31:0] exp_addr, input logic [63:0] exp_data,
                         input string tag);
    if (is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_wmask = wmask;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    #1;
    check_eq({tag, "_stall_req"}, bus.stall, 1'b1);
    for (int i = 0; i <= delay; i++) begin
      tick();
      check_eq({tag, "_mem_req"}, bus.mem_req, 1'b1);
      check_eq({tag, "_mem_addr"}, bus.mem_addr, exp_addr);
      check_eq({tag, "_mem_we"}, bus.mem_we, is_d ? we : 1'b0);
      check_eq({tag, "_mem_wmask"}, bus.mem_wmask, is_d ? wmask : 8'h00);
      check_eq({tag, "_busy_ready"}, bus.if_ready | bus.d_ready, 1'b0);
      check_eq({tag, "_busy_stall"}, bus.stall, 1'b1);
      if (is_d) check_eq({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
      if (i == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
    end
    tick();
    check_eq({tag, "_req_drop"}, bus.mem_req, 1'b0);
    check_eq({tag, "_if_ready"}, bus.if_ready, !is_d);
    check_eq({tag, "_d_ready"}, bus.d_ready, is_d);
    check_eq({tag, "_ready_stall"}, bus.stall, 1'b0);
    if (is_d && !we) check_eq({tag, "_d_rdata"}, bus.d_rdata, exp_data);
    if (!is_d) check_eq({tag, "_if_inst"}, bus.if_inst, exp_data);
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    check_eq({tag, "_post_ready"}, bus.if_ready | bus.d_ready, 1'b0);
    check_eq({tag, "_post_req"}, bus.mem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    n_checks = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    drive_idle();
    do_reset();

    run_txn(1'b0, 1'b0, 32'h0000_0104, 64'h0, 8'h0, 64'hAABBCCDD_11223344, 1,
            32'h0000_0100, 64'hAABBCCDD, "fetch_hi");
    run_txn(1'b0, 1'b0, 32'h0000_1000, 64'h0, 8'h0, 64'h55556666_77778888, 0,
            32'h0000_1000, 64'h77778888, "fetch_lo");
    run_txn(1'b1, 1'b1, 32'h0000_0200, 64'h01234567_89ABCDEF, 8'h0F, 64'h0, 3,
            32'h0000_0200, 64'h0, "store");
    check_eq("if_inst_hold", bus.if_inst, 32'h77778888);

    // Stray ack with no request outstanding.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    check_eq("stray_ack_ready", bus.if_ready | bus.d_ready, 1'b0);
    check_eq("stray_ack_rdata", bus.d_rdata, 64'h0);

    run_txn(1'b1, 1'b0, 32'h0000_0300, 64'h0, 8'h0, 64'hDEADBEEF_CAFEF00D, 0,
            32'h0000_0300, 64'hDEADBEEF_CAFEF00D, "load_fast");

    // Reset while a load is outstanding.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0400;
    tick();
    check_eq("midrst_busy", bus.mem_req, 1'b1);
    nrst = 1'b0;
    tick();
    check_eq("midrst_mem_req", bus.mem_req, 1'b0);
    check_eq("midrst_d_ready", bus.d_ready, 1'b0);
    check_eq("midrst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("midrst_d_rdata", bus.d_rdata, 64'h0);
    check_eq("midrst_if_inst", bus.if_inst, 32'h0);
    nrst = 1'b1;
    tick();
    check_eq("midrst_regrant", bus.mem_req, 1'b1);
    check_eq("midrst_readdr", bus.mem_addr, 32'h0000_0400);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h11112222_33334444;
    tick();
    check_eq("midrst_d_ready2", bus.d_ready, 1'b1);
    check_eq("midrst_d_rdata2", bus.d_rdata, 64'h11112222_33334444);
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    // Both requesters held, ack always high: expect D,D,D,D,IF,D,D,D,D,IF.
    do_reset();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0040;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0000_0080;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("starve_addr_%0d", k), bus.mem_addr,
               exp_if[k] ? 32'h0000_0040 : 32'h0000_0080);
      tick();
      check_eq($sformatf("starve_if_ready_%0d", k), bus.if_ready, exp_if[k]);
      check_eq($sformatf("starve_d_ready_%0d", k), bus.d_ready, !exp_if[k]);
    end
    drive_idle();
    tick();

    // Perf counters: 3 fetches + 2 loads, each 3 stall cycles.
    do_reset();
    run_txn(1'b0, 1'b0, 32'h0000_0000, 64'h0, 8'h0, 64'h1, 1, 32'h0, 64'h1, "perf_f0");
    run_txn(1'b1, 1'b0, 32'h0000_0008, 64'h0, 8'h0, 64'h2, 1, 32'h8, 64'h2, "perf_d0");
    run_txn(1'b0, 1'b0, 32'h0000_0010, 64'h0, 8'h0, 64'h3, 1, 32'h10, 64'h3, "perf_f1");
    run_txn(1'b1, 1'b0, 32'h0000_0018, 64'h0, 8'h0, 64'h4, 1, 32'h18, 64'h4, "perf_d1");
    run_txn(1'b0, 1'b0, 32'h0000_0020, 64'h0, 8'h0, 64'h5, 1, 32'h20, 64'h5, "perf_f2");
`ifdef ARB_PERF_CNT_EN
    check_eq("perf_if_cnt", bus.perf_if_cnt, 32'd3);
    check_eq("perf_d_cnt", bus.perf_d_cnt, 32'd2);
    check_eq("perf_wait_cnt", bus.perf_wait_cnt, 32'd15);
`else
    check_eq("perf_if_cnt", bus.perf_if_cnt, 32'd0);
    check_eq("perf_d_cnt", bus.perf_d_cnt, 32'd0);
    check_eq("perf_wait_cnt", bus.perf_wait_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
